// File: rtl/hog_bank_port_mux.sv
// Purpose : shares NUM_BANKS BRAM write ports between the host loader and the HOG result writer,
//           tracks the IDLE/SCALE/HOG/DONE job phase and feeds pixels (or a test ramp) to hog_top.
// Latency : 1 cycle on the BRAM mux and the pixel path; no backpressure, dropped host writes are flagged.
//
// Optional build macro: HOG_BANK_STATS_EN
//   defined   -> collision_cnt / host_drop track dropped host writes
//   undefined -> collision_cnt / host_drop are tied to 0 and their registers are not built
//
// Ports:
//   aclk, rst                         clock, synchronous active-high reset
//   start, scaling_finish,
//   write_feature_done                job phase control pulses
//   test_mode                         bit1 = test pixel ramp, bit2 = host override during a job
//   host_{ena,wea,addr,din}           loader write ports, bank i at [i*W +: W]
//   res_{ena,wea,addr,din}            result writer ports (always win over the host)
//   bram_{ena,wea,addr,din}           registered, muxed BRAM port A
//   p_scaling, p_valid -> p, p_valid_o pixel stream to hog_top
//   phase                             0=IDLE 1=SCALE 2=HOG 3=DONE
//   collision_cnt, host_drop          dropped-host-write statistics
module hog_bank_port_mux #(
  parameter int NUM_BANKS = 4,
  parameter int ADDR_W    = 13,
  parameter int DATA_W    = 8,
  parameter int P_WIDTH   = 8,
  parameter int TEST_WRAP = 32
) (
  input  logic                        aclk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        scaling_finish,
  input  logic                        write_feature_done,
  input  logic [31:0]                 test_mode,
  input  logic [NUM_BANKS-1:0]        host_ena,
  input  logic [NUM_BANKS-1:0]        host_wea,
  input  logic [NUM_BANKS*ADDR_W-1:0] host_addr,
  input  logic [NUM_BANKS*DATA_W-1:0] host_din,
  input  logic [NUM_BANKS-1:0]        res_ena,
  input  logic [NUM_BANKS-1:0]        res_wea,
  input  logic [NUM_BANKS*ADDR_W-1:0] res_addr,
  input  logic [NUM_BANKS*DATA_W-1:0] res_din,
  output logic [NUM_BANKS-1:0]        bram_ena,
  output logic [NUM_BANKS-1:0]        bram_wea,
  output logic [NUM_BANKS*ADDR_W-1:0] bram_addr,
  output logic [NUM_BANKS*DATA_W-1:0] bram_din,
  input  logic [P_WIDTH-1:0]          p_scaling,
  input  logic                        p_valid,
  output logic [P_WIDTH-1:0]          p,
  output logic                        p_valid_o,
  output logic [1:0]                  phase,
  output logic [15:0]                 collision_cnt,
  output logic [NUM_BANKS-1:0]        host_drop
);

  // TEST_WRAP is a power of two, so a counter of this width wraps at TEST_WRAP on its own.
  localparam int CNT_W = (TEST_WRAP > 1) ? $clog2(TEST_WRAP) : 1;

  typedef enum logic [1:0] {
    PH_IDLE  = 2'd0,
    PH_SCALE = 2'd1,
    PH_HOG   = 2'd2,
    PH_DONE  = 2'd3
  } phase_e;

  phase_e                      state_q, state_d;
  logic [NUM_BANKS-1:0]        ena_q, ena_d;
  logic [NUM_BANKS-1:0]        wea_q, wea_d;
  logic [NUM_BANKS*ADDR_W-1:0] addr_q, addr_d;
  logic [NUM_BANKS*DATA_W-1:0] din_q, din_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [P_WIDTH-1:0]          p_q, p_d;
  logic                        pv_q, pv_d;

  logic idle_like;
  logic host_window;
  logic stats_clr;

  // Only bits 1 and 2 of test_mode mean anything here.
  logic unused_test_mode;
  assign unused_test_mode = ^{test_mode[31:3], test_mode[0]};

  assign idle_like   = (state_q == PH_IDLE) || (state_q == PH_DONE);
  assign host_window = idle_like || test_mode[2];
  // A new job starts with clean statistics.
  assign stats_clr   = idle_like && start;

  // Phase FSM: out-of-phase pulses simply fall through to the hold default.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      PH_IDLE:  if (start)              state_d = PH_SCALE;
      PH_SCALE: if (scaling_finish)     state_d = PH_HOG;
      PH_HOG:   if (write_feature_done) state_d = PH_DONE;
      PH_DONE:  if (start)              state_d = PH_SCALE;
      default:                          state_d = PH_IDLE;
    endcase
  end

  // Per-bank port mux; an idle bank keeps its last addr/din to avoid needless toggling.
  always_comb begin
    ena_d  = '0;
    wea_d  = '0;
    addr_d = addr_q;
    din_d  = din_q;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (res_ena[i]) begin
        ena_d[i]                   = 1'b1;
        wea_d[i]                   = res_wea[i];
        addr_d[i*ADDR_W +: ADDR_W] = res_addr[i*ADDR_W +: ADDR_W];
        din_d[i*DATA_W +: DATA_W]  = res_din[i*DATA_W +: DATA_W];
      end else if (host_ena[i] && host_window) begin
        ena_d[i]                   = 1'b1;
        wea_d[i]                   = host_wea[i];
        addr_d[i*ADDR_W +: ADDR_W] = host_addr[i*ADDR_W +: ADDR_W];
        din_d[i*DATA_W +: DATA_W]  = host_din[i*DATA_W +: DATA_W];
      end
    end
  end

  // Pixel path and test ramp. The ramp value shown is the one before this cycle's increment.
  always_comb begin
    cnt_d = cnt_q;
    if (scaling_finish) begin
      cnt_d = '0;
    end else if (p_valid) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    pv_d = p_valid;
    p_d  = '0;
    if (test_mode[1]) begin
      p_d[CNT_W-1:0] = cnt_q;
    end else begin
      p_d = p_scaling;
    end
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      state_q <= PH_IDLE;
      ena_q   <= '0;
      wea_q   <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
      pv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ena_q   <= ena_d;
      wea_q   <= wea_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      pv_q    <= pv_d;
    end
  end

`ifdef HOG_BANK_STATS_EN
  logic [NUM_BANKS-1:0] drop_vec;
  logic [NUM_BANKS-1:0] host_drop_q, host_drop_d;
  logic [15:0]          coll_q, coll_d;

  // A host write is lost if the result writer owns the bank or the window is shut.
  assign drop_vec = host_ena & (res_ena | {NUM_BANKS{~host_window}});

  // Clearing on job start takes priority; drops seen in that cycle belong to the finished job.
  always_comb begin
    host_drop_d = host_drop_q | drop_vec;
    coll_d      = coll_q;
    if ((|drop_vec) && (coll_q != 16'hFFFF)) begin
      coll_d = coll_q + 16'd1;
    end
    if (stats_clr) begin
      host_drop_d = '0;
      coll_d      = '0;
    end
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      host_drop_q <= '0;
      coll_q      <= '0;
    end else begin
      host_drop_q <= host_drop_d;
      coll_q      <= coll_d;
    end
  end

  assign host_drop     = host_drop_q;
  assign collision_cnt = coll_q;
`else
  logic unused_stats;
  assign unused_stats  = stats_clr;
  assign host_drop     = '0;
  assign collision_cnt = '0;
`endif

  assign bram_ena  = ena_q;
  assign bram_wea  = wea_q;
  assign bram_addr = addr_q;
  assign bram_din  = din_q;
  assign p         = p_q;
  assign p_valid_o = pv_q;
  assign phase     = state_q;

endmodule

// File: tb/tb_hog_bank_port_mux.sv
// Directed bench for hog_bank_port_mux: host/result muxing, drop statistics,
// phase sequencing, test pixel ramp and reset abort.
// Statistics expectations collapse to 0 when HOG_BANK_STATS_EN is not defined.
module tb_hog_bank_port_mux;

  localparam int NB = 4;
  localparam int AW = 13;
  localparam int DW = 8;
  localparam int PW = 8;

`ifdef HOG_BANK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic           aclk = 1'b0;
  logic           rst;
  logic           start, scaling_finish, write_feature_done;
  logic [31:0]    test_mode;
  logic [NB-1:0]  host_ena, host_wea, res_ena, res_wea;
  logic [NB*AW-1:0] host_addr, res_addr;
  logic [NB*DW-1:0] host_din, res_din;
  logic [NB-1:0]  bram_ena, bram_wea;
  logic [NB*AW-1:0] bram_addr;
  logic [NB*DW-1:0] bram_din;
  logic [PW-1:0]  p_scaling, p;
  logic           p_valid, p_valid_o;
  logic [1:0]     phase;
  logic [15:0]    collision_cnt;
  logic [NB-1:0]  host_drop;

  int total = 0;
  int bad   = 0;

  hog_bank_port_mux #(
    .NUM_BANKS(NB), .ADDR_W(AW), .DATA_W(DW), .P_WIDTH(PW), .TEST_WRAP(32)
  ) dut (
    .aclk(aclk), .rst(rst), .start(start), .scaling_finish(scaling_finish),
    .write_feature_done(write_feature_done), .test_mode(test_mode),
    .host_ena(host_ena), .host_wea(host_wea), .host_addr(host_addr), .host_din(host_din),
    .res_ena(res_ena), .res_wea(res_wea), .res_addr(res_addr), .res_din(res_din),
    .bram_ena(bram_ena), .bram_wea(bram_wea), .bram_addr(bram_addr), .bram_din(bram_din),
    .p_scaling(p_scaling), .p_valid(p_valid), .p(p), .p_valid_o(p_valid_o),
    .phase(phase), .collision_cnt(collision_cnt), .host_drop(host_drop)
  );

  always #5 aclk = ~aclk;

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic clear_inputs();
    rst = 1'b0; start = 1'b0; scaling_finish = 1'b0; write_feature_done = 1'b0;
    test_mode = '0;
    host_ena = '0; host_wea = '0; host_addr = '0; host_din = '0;
    res_ena = '0; res_wea = '0; res_addr = '0; res_din = '0;
    p_scaling = '0; p_valid = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    total++; if (phase !== 2'd0) begin bad++; $display("FAIL reset_phase got=%0d want=0", phase); end
    total++; if (bram_ena !== 4'b0) begin bad++; $display("FAIL reset_ena got=%b want=0000", bram_ena); end
    total++; if (bram_addr !== '0) begin bad++; $display("FAIL reset_addr got=%h want=0", bram_addr); end
    total++; if (p !== 8'd0 || p_valid_o !== 1'b0) begin bad++; $display("FAIL reset_pix got=%h/%b want=0/0", p, p_valid_o); end
    total++; if (collision_cnt !== 16'd0 || host_drop !== 4'b0) begin bad++; $display("FAIL reset_stats got=%0d/%b want=0/0000", collision_cnt, host_drop); end
  endtask

  task automatic test_host_idle();
    host_ena = 4'b0001; host_wea = 4'b0001;
    host_addr[0*AW +: AW] = 13'd5; host_din[0*DW +: DW] = 8'hA5;
    step();
    total++; if (bram_ena !== 4'b0001 || bram_wea !== 4'b0001) begin bad++; $display("FAIL host_idle_ena got=%b/%b want=0001/0001", bram_ena, bram_wea); end
    total++; if (bram_addr[0*AW +: AW] !== 13'd5) begin bad++; $display("FAIL host_idle_addr got=%0d want=5", bram_addr[0*AW +: AW]); end
    total++; if (bram_din[0*DW +: DW] !== 8'hA5) begin bad++; $display("FAIL host_idle_din got=%h want=a5", bram_din[0*DW +: DW]); end
    total++; if (collision_cnt !== 16'd0) begin bad++; $display("FAIL host_idle_cnt got=%0d want=0", collision_cnt); end
    clear_inputs();
    step();
    total++; if (bram_ena !== 4'b0 || bram_wea !== 4'b0) begin bad++; $display("FAIL host_release got=%b/%b want=0000/0000", bram_ena, bram_wea); end
    total++; if (bram_addr[0*AW +: AW] !== 13'd5 || bram_din[0*DW +: DW] !== 8'hA5) begin bad++; $display("FAIL host_hold got=%0d/%h want=5/a5", bram_addr[0*AW +: AW], bram_din[0*DW +: DW]); end
  endtask

  task automatic test_collision();
    res_ena = 4'b1000; res_wea = 4'b1000;
    res_addr[3*AW +: AW] = 13'd7; res_din[3*DW +: DW] = 8'h3C;
    host_ena = 4'b1000; host_wea = 4'b1000;
    host_addr[3*AW +: AW] = 13'd9; host_din[3*DW +: DW] = 8'h55;
    step();
    total++; if (bram_ena !== 4'b1000) begin bad++; $display("FAIL coll_ena got=%b want=1000", bram_ena); end
    total++; if (bram_addr[3*AW +: AW] !== 13'd7 || bram_din[3*DW +: DW] !== 8'h3C) begin bad++; $display("FAIL coll_res_wins got=%0d/%h want=7/3c", bram_addr[3*AW +: AW], bram_din[3*DW +: DW]); end
    total++; if (host_drop !== (STATS ? 4'b1000 : 4'b0)) begin bad++; $display("FAIL coll_drop got=%b want=%b", host_drop, (STATS ? 4'b1000 : 4'b0)); end
    total++; if (collision_cnt !== (STATS ? 16'd1 : 16'd0)) begin bad++; $display("FAIL coll_cnt got=%0d want=%0d", collision_cnt, (STATS ? 1 : 0)); end
    // Two banks colliding in one cycle count once.
    clear_inputs();
    res_ena = 4'b0011; host_ena = 4'b0011;
    step();
    total++; if (collision_cnt !== (STATS ? 16'd2 : 16'd0)) begin bad++; $display("FAIL coll_per_cycle got=%0d want=%0d", collision_cnt, (STATS ? 2 : 0)); end
    total++; if (host_drop !== (STATS ? 4'b1011 : 4'b0)) begin bad++; $display("FAIL coll_sticky got=%b want=%b", host_drop, (STATS ? 4'b1011 : 4'b0)); end
    clear_inputs();
  endtask

  task automatic test_phase_and_drop();
    start = 1'b1; step(); start = 1'b0;
    total++; if (phase !== 2'd1) begin bad++; $display("FAIL ph_start got=%0d want=1", phase); end
    total++; if (collision_cnt !== 16'd0 || host_drop !== 4'b0) begin bad++; $display("FAIL ph_start_clr got=%0d/%b want=0/0000", collision_cnt, host_drop); end
    host_ena = 4'b0010; host_wea = 4'b0010;
    host_addr[1*AW +: AW] = 13'd11; host_din[1*DW +: DW] = 8'h42;
    step();
    total++; if (bram_ena !== 4'b0) begin bad++; $display("FAIL scale_block got=%b want=0000", bram_ena); end
    total++; if (host_drop !== (STATS ? 4'b0010 : 4'b0) || collision_cnt !== (STATS ? 16'd1 : 16'd0)) begin bad++; $display("FAIL scale_drop got=%b/%0d want=%b/%0d", host_drop, collision_cnt, (STATS ? 4'b0010 : 4'b0), (STATS ? 1 : 0)); end
    test_mode = 32'h4;
    step();
    total++; if (bram_ena !== 4'b0010 || bram_addr[1*AW +: AW] !== 13'd11) begin bad++; $display("FAIL scale_override got=%b/%0d want=0010/11", bram_ena, bram_addr[1*AW +: AW]); end
    total++; if (collision_cnt !== (STATS ? 16'd1 : 16'd0)) begin bad++; $display("FAIL scale_override_cnt got=%0d want=%0d", collision_cnt, (STATS ? 1 : 0)); end
    clear_inputs();
    start = 1'b1; step(); start = 1'b0;
    write_feature_done = 1'b1; step(); write_feature_done = 1'b0;
    total++; if (phase !== 2'd1) begin bad++; $display("FAIL ph_scale_ignore got=%0d want=1", phase); end
    scaling_finish = 1'b1; step(); scaling_finish = 1'b0;
    total++; if (phase !== 2'd2) begin bad++; $display("FAIL ph_hog got=%0d want=2", phase); end
    start = 1'b1; step(); start = 1'b0;
    scaling_finish = 1'b1; step(); scaling_finish = 1'b0;
    total++; if (phase !== 2'd2) begin bad++; $display("FAIL ph_hog_ignore got=%0d want=2", phase); end
    res_ena = 4'b0001; res_wea = 4'b0001;
    res_addr[0*AW +: AW] = 13'h1ABC; res_din[0*DW +: DW] = 8'h99;
    step();
    total++; if (bram_ena !== 4'b0001 || bram_addr[0*AW +: AW] !== 13'h1ABC || bram_din[0*DW +: DW] !== 8'h99) begin bad++; $display("FAIL hog_res got=%b/%h/%h want=0001/1abc/99", bram_ena, bram_addr[0*AW +: AW], bram_din[0*DW +: DW]); end
    clear_inputs();
    write_feature_done = 1'b1; step(); write_feature_done = 1'b0;
    total++; if (phase !== 2'd3) begin bad++; $display("FAIL ph_done got=%0d want=3", phase); end
    host_ena = 4'b0100;
    step();
    total++; if (bram_ena !== 4'b0100) begin bad++; $display("FAIL done_window got=%b want=0100", bram_ena); end
    total++; if (collision_cnt !== (STATS ? 16'd1 : 16'd0)) begin bad++; $display("FAIL done_cnt_kept got=%0d want=%0d", collision_cnt, (STATS ? 1 : 0)); end
    clear_inputs();
    start = 1'b1; step(); start = 1'b0;
    total++; if (phase !== 2'd1 || collision_cnt !== 16'd0 || host_drop !== 4'b0) begin bad++; $display("FAIL ph_restart got=%0d/%0d/%b want=1/0/0000", phase, collision_cnt, host_drop); end
  endtask

  task automatic test_pixels();
    logic [PW-1:0] want;
    test_mode = 32'h2;
    p_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      step();
      want = PW'(k % 32);
      total++; if (p !== want || p_valid_o !== 1'b1) begin bad++; $display("FAIL ramp_%0d got=%0d/%b want=%0d/1", k, p, p_valid_o, want); end
    end
    scaling_finish = 1'b1;
    step();
    total++; if (p !== 8'd8 || p_valid_o !== 1'b1) begin bad++; $display("FAIL ramp_clr_same got=%0d/%b want=8/1", p, p_valid_o); end
    scaling_finish = 1'b0; p_valid = 1'b0;
    step();
    total++; if (p !== 8'd0 || p_valid_o !== 1'b0) begin bad++; $display("FAIL ramp_clr_next got=%0d/%b want=0/0", p, p_valid_o); end
    test_mode = 32'h0; p_scaling = 8'h7E; p_valid = 1'b1;
    step();
    total++; if (p !== 8'h7E || p_valid_o !== 1'b1) begin bad++; $display("FAIL pass_pix got=%h/%b want=7e/1", p, p_valid_o); end
    test_mode = 32'h2; p_valid = 1'b0;
    step();
    total++; if (p !== 8'd1 || p_valid_o !== 1'b0) begin bad++; $display("FAIL mode_switch got=%0d/%b want=1/0", p, p_valid_o); end
    clear_inputs();
  endtask

  task automatic test_reset_mid_job();
    // Phase is HOG here: the ramp's scaling_finish moved SCALE -> HOG.
    total++; if (phase !== 2'd2) begin bad++; $display("FAIL pre_abort_phase got=%0d want=2", phase); end
    res_ena = 4'hF; res_wea = 4'hF; p_valid = 1'b1; rst = 1'b1;
    step();
    total++; if (phase !== 2'd0 || bram_ena !== 4'b0 || p_valid_o !== 1'b0) begin bad++; $display("FAIL abort got=%0d/%b/%b want=0/0000/0", phase, bram_ena, p_valid_o); end
    clear_inputs();
    step();
    total++; if (phase !== 2'd0 || bram_ena !== 4'b0) begin bad++; $display("FAIL post_abort got=%0d/%b want=0/0000", phase, bram_ena); end
  endtask

  initial begin
    test_reset();
    test_host_idle();
    test_collision();
    test_phase_and_drop();
    test_pixels();
    test_reset_mid_job();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
